line_writer: RTL and testbench
==============================

# line_writer

Dirty-line writeback engine for the L1 caches. Accepts one 64-byte line plus its address from a cache controller and drives it onto the system bus as a memory WRITE: one address beat, held until acknowledged, followed by eight data beats. It is the write-side counterpart to the cache's line fetch path and shares the same bus request channel.

## Interface
- BUS_DATA_WIDTH, 64, width of one bus beat; the line is 512 bits, so 512/BUS_DATA_WIDTH = 8 beats.
- BUS_TAG_WIDTH, 13, width of the bus request tag.

- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  input  1  writeback request present.
- in_addr  input  64  physical address of the line; low 6 bits ignored.
- in_data  input  512  line contents; bits [64k+63:64k] are beat k.
- in_ready  output  1  engine idle; request is accepted when in_valid && in_ready.
- out_done  output  1  one-cycle pulse after the last data beat.
- bus_reqcyc  output  1  request channel valid.
- bus_req  output  BUS_DATA_WIDTH  address beat, then data beats.
- bus_reqtag  output  BUS_TAG_WIDTH  request tag.
- bus_reqack  input  1  bus accepted the address beat.

## Operation
- States: IDLE, ADDR, DATA, DONE. Reset forces IDLE.
- IDLE: in_ready=1, bus outputs 0.
  - On in_valid, capture in_addr & ~63 and in_data into internal registers.
  - Clear the beat counter, then go to ADDR.
- ADDR:
  - Drive bus_reqcyc=1 and bus_req=captured address.
  - Drive bus_reqtag[12]=0 (WRITE), [11:8]=4'b0001 (MEMORY), [7:0]=0.
  - Hold these until bus_reqack is sampled high, then go to DATA.
- DATA:
  - Drive bus_reqcyc=1 and bus_req=line[64·beat +: 64], with the tag unchanged.
  - beat is a 3-bit counter that increments every cycle, unconditionally. There is no per-beat ack, and bus_reqack is ignored in this state.
  - After beat 7 is driven, go to DONE.
- DONE:
  - Drive bus outputs 0 and out_done=1 for exactly one cycle, then return to IDLE.
  - in_ready stays 0 during DONE, so a request presented here is not taken.
- Address alignment: bits [5:0] of bus_req on the address beat are always 0.
- The captured line is frozen from acceptance to DONE. Changes on in_addr or in_data during that time have no effect.
- Reset mid-operation:
  - Abandon the line and go to IDLE.
  - All outputs take their reset values on the next edge.
  - No out_done is generated.

## Timing
- Reset values: in_ready=1, out_done=0, bus_reqcyc=0, bus_req=0, bus_reqtag=0. State=IDLE, beat=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from bus_reqack or in_valid to any output.
- Cycle T: acceptance edge.
  - T+1: first address beat.
  - If bus_reqack is high in the cycle the address is shown at edge A, data beat 0 is at A+1 and beat 7 is at A+8.
  - out_done is at A+9, and in_ready returns at A+10.
- Minimum accept-to-accept spacing: 11 cycles when ack is immediate. bus_reqcyc is high for 9 consecutive cycles minimum.
- bus_reqack stalls: each cycle it is low in ADDR extends ADDR by one cycle, with the address and tag held stable.
- bus_reqack high in IDLE or DONE is ignored.

## Structure
- Shared package sysbus_pkg holds the Sysbus.defs constants: READ/WRITE tag bit, MEMORY type code 4'b0001, and the tag field positions. The fetch path uses the same constants.
- State enum line_writer_state_t also lives in sysbus_pkg.
- No sub-module. Beat selection is an indexed part-select of the captured line; a shift register is acceptable if it yields the same beat order.
- Target size is 120–200 lines of RTL.

## Test plan
- Basic write:
  - Stimulus: in_addr=0x0000_1234, line beats k = 0x1111_1111_1111_1111·(k+1), ack on the first address cycle.
  - Required: address beat 0x1200 with tag 13'h0100, then beats 0x1111…, 0x2222…, … 0x8888… on 8 consecutive cycles, then out_done one cycle later.
- Ack stall:
  - Stimulus: hold bus_reqack low for 5 cycles in ADDR.
  - Required: bus_req=0x1200 and tag held for 6 cycles; data beats begin the cycle after ack; no beat is skipped or duplicated.
- Back-to-back:
  - Stimulus: in_valid held high with two different lines.
  - Required: second line accepted only when in_ready rises after DONE; both lines appear complete and in order; exactly two out_done pulses.
- Input change during transfer:
  - Stimulus: alter in_data/in_addr every cycle after acceptance.
  - Required: bus beats match the values captured at acceptance.
- Reset mid-DATA:
  - Stimulus: assert reset during beat 3.
  - Required: next cycle bus_reqcyc=0, bus_req=0, in_ready=1, no out_done; a new request afterwards starts a fresh address beat.
- Spurious ack:
  - Stimulus: bus_reqack pulsed in IDLE and during DATA.
  - Required: no state change and no effect on beat sequencing.

Source files
------------

// File: rtl/sysbus_pkg.sv
// System bus definitions shared by the cache line fetch and writeback paths.
// Holds the request tag layout and the writeback engine state encoding.
package sysbus_pkg;

    localparam int TAG_WIDTH   = 13;
    localparam int TAG_RW_BIT  = 12;
    localparam int TAG_TYPE_HI = 11;
    localparam int TAG_TYPE_LO = 8;

    localparam logic       TAG_READ    = 1'b1;
    localparam logic       TAG_WRITE   = 1'b0;
    localparam logic [3:0] TYPE_MEMORY = 4'b0001;

    localparam int LINE_BITS        = 512;
    localparam int LINE_OFFSET_BITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } line_writer_state_t;

    // Request tag with the low id byte zeroed.
    function automatic logic [TAG_WIDTH-1:0] make_tag(input logic rw, input logic [3:0] kind);
        logic [TAG_WIDTH-1:0] t;
        t = '0;
        t[TAG_RW_BIT] = rw;
        t[TAG_TYPE_HI:TAG_TYPE_LO] = kind;
        return t;
    endfunction

endpackage

// File: rtl/line_writer_if.sv
// Cache-side request/completion and system-bus request channel of the line writer.
// master is the engine; slave is the cache controller plus bus side.
interface line_writer_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      in_valid;
    logic [63:0]               in_addr;
    logic [511:0]              in_data;
    logic                      in_ready;
    logic                      out_done;
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;

    modport master (
        input  in_valid, in_addr, in_data, bus_reqack,
        output in_ready, out_done, bus_reqcyc, bus_req, bus_reqtag
    );

    modport slave (
        output in_valid, in_addr, in_data, bus_reqack,
        input  in_ready, out_done, bus_reqcyc, bus_req, bus_reqtag
    );
endinterface

// File: rtl/line_writer.sv
// Dirty-line writeback engine: one held address beat, then the captured line
// streamed as back-to-back data beats, then a one-cycle done pulse.
module line_writer
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic          clk,
    input  logic          reset,
    line_writer_if.master bus
);

    localparam int BEATS  = LINE_BITS / BUS_DATA_WIDTH;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [63:0] OFFSET_MASK = (64'd1 << LINE_OFFSET_BITS) - 64'd1;

    line_writer_state_t     state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [63:0]            addr_q, addr_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0] wr_tag;

    assign wr_tag = BUS_TAG_WIDTH'(make_tag(TAG_WRITE, TYPE_MEMORY));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    // Line and address are only written on acceptance, so they stay frozen
    // for the whole transfer regardless of what the inputs do.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    addr_d  = bus.in_addr & ~OFFSET_MASK;
                    line_d  = bus.in_data;
                    beat_d  = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.bus_reqack) state_d = DATA;
            end
            DATA: begin
                // No per-beat handshake: the bus takes one beat every cycle.
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_W'(BEATS - 1)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only.
    always_comb begin
        bus.in_ready   = 1'b0;
        bus.out_done   = 1'b0;
        bus.bus_reqcyc = 1'b0;
        bus.bus_req    = '0;
        bus.bus_reqtag = '0;
        case (state_q)
            IDLE: bus.in_ready = 1'b1;
            ADDR: begin
                bus.bus_reqcyc = 1'b1;
                bus.bus_req    = addr_q[BUS_DATA_WIDTH-1:0];
                bus.bus_reqtag = wr_tag;
            end
            DATA: begin
                bus.bus_reqcyc = 1'b1;
                bus.bus_req    = line_q[int'(beat_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                bus.bus_reqtag = wr_tag;
            end
            DONE: bus.out_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_writer.sv
// Directed bench for line_writer: inputs driven and outputs checked on the
// falling edge, expected beats built from hand-chosen line patterns.
module tb_line_writer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    line_writer_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) lw ();

    line_writer #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (lw)
    );

    localparam logic [63:0] WR_TAG = 64'h0100;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always @(posedge clk) if (lw.out_done === 1'b1) done_cnt++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = base * 64'(k + 1);
        return l;
    endfunction

    task automatic accept(input string nm, input logic [63:0] addr, input logic [511:0] line);
        lw.in_valid = 1'b1;
        lw.in_addr  = addr;
        lw.in_data  = line;
        chk({nm, "_ready"}, 64'(lw.in_ready), 64'd1);
        tick();
        lw.in_valid = 1'b0;
    endtask

    // Entered on the first ADDR cycle; leaves on the first IDLE cycle after DONE.
    task automatic run_xfer(input string nm, input logic [63:0] aexp, input logic [511:0] lexp,
                            input int stall, input bit scramble, input bit spur);
        for (int s = 0; s <= stall; s++) begin
            lw.bus_reqack = (s == stall);
            if (scramble) begin
                lw.in_addr = {$urandom(), $urandom()};
                lw.in_data = {16{$urandom()}};
            end
            chk($sformatf("%s_acyc%0d", nm, s), 64'(lw.bus_reqcyc), 64'd1);
            chk($sformatf("%s_addr%0d", nm, s), lw.bus_req, aexp);
            chk($sformatf("%s_atag%0d", nm, s), 64'(lw.bus_reqtag), WR_TAG);
            chk($sformatf("%s_abusy%0d", nm, s), 64'(lw.in_ready), 64'd0);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            lw.bus_reqack = spur && (k == 2 || k == 5);
            if (scramble) begin
                lw.in_addr = {$urandom(), $urandom()};
                lw.in_data = {16{$urandom()}};
            end
            chk($sformatf("%s_dcyc%0d", nm, k), 64'(lw.bus_reqcyc), 64'd1);
            chk($sformatf("%s_beat%0d", nm, k), lw.bus_req, lexp[64*k +: 64]);
            chk($sformatf("%s_dtag%0d", nm, k), 64'(lw.bus_reqtag), WR_TAG);
            chk($sformatf("%s_ddone%0d", nm, k), 64'(lw.out_done), 64'd0);
            tick();
        end
        lw.bus_reqack = 1'b0;
        chk({nm, "_done"}, 64'(lw.out_done), 64'd1);
        chk({nm, "_done_cyc"}, 64'(lw.bus_reqcyc), 64'd0);
        chk({nm, "_done_req"}, lw.bus_req, 64'd0);
        chk({nm, "_done_busy"}, 64'(lw.in_ready), 64'd0);
        tick();
        chk({nm, "_idle_done"}, 64'(lw.out_done), 64'd0);
        chk({nm, "_idle_ready"}, 64'(lw.in_ready), 64'd1);
    endtask

    initial begin
        logic [511:0] l1, l2, l3;
        int d0;
        l1 = mk_line(64'h1111_1111_1111_1111);
        l2 = mk_line(64'h0101_0202_0303_0404);
        l3 = mk_line(64'h00A5_5A00_C3C3_0001);

        lw.in_valid   = 1'b0;
        lw.in_addr    = '0;
        lw.in_data    = '0;
        lw.bus_reqack = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_ready", 64'(lw.in_ready), 64'd1);
        chk("rst_done", 64'(lw.out_done), 64'd0);
        chk("rst_cyc", 64'(lw.bus_reqcyc), 64'd0);
        chk("rst_req", lw.bus_req, 64'd0);
        chk("rst_tag", 64'(lw.bus_reqtag), 64'd0);
        reset = 1'b0;
        tick();

        // Ack while idle must not start anything
        lw.bus_reqack = 1'b1;
        tick();
        lw.bus_reqack = 1'b0;
        chk("idle_ack_ready", 64'(lw.in_ready), 64'd1);
        chk("idle_ack_cyc", 64'(lw.bus_reqcyc), 64'd0);
        tick();
        chk("idle_ack_ready2", 64'(lw.in_ready), 64'd1);

        d0 = done_cnt;
        accept("basic", 64'h0000_0000_0000_1234, l1);
        run_xfer("basic", 64'h0000_0000_0000_1200, l1, 0, 1'b0, 1'b0);
        chk("basic_done_count", 64'(done_cnt - d0), 64'd1);

        accept("stall", 64'h0000_0000_0000_1234, l1);
        run_xfer("stall", 64'h0000_0000_0000_1200, l1, 5, 1'b0, 1'b0);

        accept("scr", 64'hFFFF_FFFF_FFFF_FFFF, l3);
        run_xfer("scr", 64'hFFFF_FFFF_FFFF_FFC0, l3, 2, 1'b1, 1'b0);

        accept("spur", 64'h0000_0000_8000_0040, l2);
        run_xfer("spur", 64'h0000_0000_8000_0040, l2, 0, 1'b0, 1'b1);

        // Back-to-back with in_valid held high across DONE
        d0 = done_cnt;
        lw.in_valid = 1'b1;
        lw.in_addr  = 64'h0000_0001_0000_00BF;
        lw.in_data  = l1;
        tick();
        lw.in_addr  = 64'h0000_0002_0000_0101;
        lw.in_data  = l2;
        run_xfer("b2b0", 64'h0000_0001_0000_0080, l1, 0, 1'b0, 1'b0);
        tick();
        lw.in_valid = 1'b0;
        run_xfer("b2b1", 64'h0000_0002_0000_0100, l2, 0, 1'b0, 1'b0);
        chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);

        // Reset during data beat 3
        d0 = done_cnt;
        accept("rst_mid", 64'h0000_0000_0000_2000, l1);
        lw.bus_reqack = 1'b1;
        chk("rst_mid_addr", lw.bus_req, 64'h2000);
        tick();
        lw.bus_reqack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_mid_beat%0d", k), lw.bus_req, l1[64*k +: 64]);
            if (k < 3) tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_cyc", 64'(lw.bus_reqcyc), 64'd0);
        chk("rst_mid_req", lw.bus_req, 64'd0);
        chk("rst_mid_tag", 64'(lw.bus_reqtag), 64'd0);
        chk("rst_mid_ready", 64'(lw.in_ready), 64'd1);
        chk("rst_mid_done", 64'(lw.out_done), 64'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("rst_mid_ready_later", 64'(lw.in_ready), 64'd1);
        chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);

        accept("post_rst", 64'h0000_0000_0000_3005, l2);
        run_xfer("post_rst", 64'h0000_0000_0000_3000, l2, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
